precision_operand_stager: RTL and testbench

Streaming front-end for the mixed-precision butterfly. Accepts complex FP8 samples one per handshake, converts them to the frame's adder precision (FP8 pass-through or FP8→FP4 with round/saturate/flush), pairs consecutive samples into butterfly operands {A, B], and buffers pairs in a 2-entry output FIFO. Sits directly upstream of the butterfly; its outputs feed the butterfly's A/B operand ports.

---
 rtl/precision_operand_stager_if.sv | 24 ++
 rtl/precision_operand_stager.sv | 212 +++++++++++++++++++++
 tb/tb_precision_operand_stager.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/precision_operand_stager_if.sv
// Operand-stager bus: FP8 sample stream in, butterfly operand pairs out.
interface precision_operand_stager_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        cfg_fp4;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic        out_fp4;
  logic        out_last;

  modport slave (
    input  in_valid, in_data, in_last, cfg_fp4, out_ready,
    output in_ready, out_valid, out_a, out_b, out_fp4, out_last
  );

  modport master (
    output in_valid, in_data, in_last, cfg_fp4, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_fp4, out_last
  );
endinterface

// File: rtl/precision_operand_stager.sv
// FP8 sample stager: optional FP8->FP4 conversion, A/B pairing, 2-entry pair FIFO.
// Optional macro PREC_EVENT_CNT_EN enables the saturation/underflow event counters.
module precision_operand_stager #(
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  precision_operand_stager_if.slave bus,
  output logic [CNT_W-1:0]          sat_cnt,
  output logic [CNT_W-1:0]          uflow_cnt
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_HOLD_A = 1'b1;

  // Round-to-FP4 with flush below e8=6 and clamp above e8=9.
  function automatic logic [3:0] fp8_to_fp4(input logic [7:0] x);
    logic [3:0] e_adj;
    logic [3:0] r;
    e_adj = x[6:3] - 4'd6;
    if (x[6:3] < 4'd6) begin
      r = {x[7], 3'b000};
    end else if (x[6:3] > 4'd9) begin
      r = {x[7], 3'b111};
    end else begin
      r = {x[7], e_adj[1:0], x[2] | (x[1] & x[0])};
    end
    return r;
  endfunction

  logic [0:0]  state_q, state_d;
  logic [15:0] a_q, a_d;
  logic        frame_fp4_q, frame_fp4_d;
  logic        sof_q, sof_d;

  logic [15:0] mem_a_q [2];
  logic [15:0] mem_b_q [2];
  logic        mem_fp4_q [2];
  logic        mem_last_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;

  logic        in_ready_s;
  logic        accept_s;
  logic        pop_s;
  logic        eff_fp4_s;
  logic [15:0] conv_s;
  logic        push_s;
  logic [15:0] push_a_s;
  logic [15:0] push_b_s;
  logic        push_last_s;

  assign in_ready_s = (count_q != 2'd2);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign pop_s      = (count_q != 2'd0) && bus.out_ready;
  // The first sample of a frame uses the live cfg_fp4; later samples use the latched tag.
  assign eff_fp4_s  = sof_q ? bus.cfg_fp4 : frame_fp4_q;
  assign conv_s     = eff_fp4_s ? {8'h00, fp8_to_fp4(bus.in_data[15:8]), fp8_to_fp4(bus.in_data[7:0])}
                                : bus.in_data;

  // Pairing FSM next state and FIFO push request.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    frame_fp4_d = frame_fp4_q;
    sof_d       = sof_q;
    push_s      = 1'b0;
    push_a_s    = conv_s;
    push_b_s    = 16'h0000;
    push_last_s = bus.in_last;
    if (accept_s) begin
      sof_d = bus.in_last;
      if (sof_q) begin
        frame_fp4_d = bus.cfg_fp4;
      end else begin
        frame_fp4_d = frame_fp4_q;
      end
      case (state_q)
        ST_IDLE: begin
          a_d = conv_s;
          if (bus.in_last) begin
            push_s  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD_A;
          end
        end
        ST_HOLD_A: begin
          push_s   = 1'b1;
          push_a_s = a_q;
          push_b_s = conv_s;
          state_d  = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FIFO occupancy next state.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pairing state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= 16'h0000;
      frame_fp4_q <= 1'b0;
      sof_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      frame_fp4_q <= frame_fp4_d;
      sof_q       <= sof_d;
    end
  end

  // FIFO storage and pointers; entries are cleared so the idle head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_a_q[i]    <= 16'h0000;
        mem_b_q[i]    <= 16'h0000;
        mem_fp4_q[i]  <= 1'b0;
        mem_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_s) begin
        mem_a_q[wr_ptr_q]    <= push_a_s;
        mem_b_q[wr_ptr_q]    <= push_b_s;
        mem_fp4_q[wr_ptr_q]  <= eff_fp4_s;
        mem_last_q[wr_ptr_q] <= push_last_s;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_a     = mem_a_q[rd_ptr_q];
  assign bus.out_b     = mem_b_q[rd_ptr_q];
  assign bus.out_fp4   = mem_fp4_q[rd_ptr_q];
  assign bus.out_last  = mem_last_q[rd_ptr_q];

`ifdef PREC_EVENT_CNT_EN
  function automatic logic is_sat(input logic [7:0] x);
    return (x[6:3] > 4'd9);
  endfunction

  function automatic logic is_uflow(input logic [7:0] x);
    return (x[6:3] < 4'd6) && (x[6:0] != 7'd0);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] sat_q, sat_d, uflow_q, uflow_d;
  logic [1:0]       sat_inc_s, uflow_inc_s;

  // Per-sample event increments, real and imag counted independently.
  always_comb begin
    sat_inc_s   = 2'd0;
    uflow_inc_s = 2'd0;
    if (accept_s && eff_fp4_s) begin
      sat_inc_s   = {1'b0, is_sat(bus.in_data[15:8])}   + {1'b0, is_sat(bus.in_data[7:0])};
      uflow_inc_s = {1'b0, is_uflow(bus.in_data[15:8])} + {1'b0, is_uflow(bus.in_data[7:0])};
    end else begin
      sat_inc_s   = 2'd0;
      uflow_inc_s = 2'd0;
    end
    sat_d   = sat_add(sat_q, sat_inc_s);
    uflow_d = sat_add(uflow_q, uflow_inc_s);
  end

  // Event counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q   <= {CNT_W{1'b0}};
      uflow_q <= {CNT_W{1'b0}};
    end else begin
      sat_q   <= sat_d;
      uflow_q <= uflow_d;
    end
  end

  assign sat_cnt   = sat_q;
  assign uflow_cnt = uflow_q;
`else
  assign sat_cnt   = {CNT_W{1'b0}};
  assign uflow_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_precision_operand_stager.sv
// Scoreboard bench for precision_operand_stager against a sample-list reference model.
module tb_precision_operand_stager;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        fp4;
    logic        last;
  } pair_t;

`ifdef PREC_EVENT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sat_cnt, uflow_cnt;

  precision_operand_stager_if bus ();

  precision_operand_stager #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sat_cnt   (sat_cnt),
    .uflow_cnt (uflow_cnt)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  pair_t sb[$];

  logic [15:0] pend[$];
  bit          m_sof = 1'b1;
  bit          m_mode = 1'b0;
  int          m_sat = 0;
  int          m_uf = 0;
  bit          rnd_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference FP8 -> FP4 from the numeric rules.
  function automatic logic [3:0] ref_cvt(input logic [7:0] x);
    int e, m;
    logic [1:0] e4;
    e = int'(x[6:3]);
    m = int'(x[2:0]);
    if (e < 6) return {x[7], 3'b000};
    if (e > 9) return {x[7], 3'b111};
    e4 = 2'(e - 6);
    return {x[7], e4, (m >= 3)};
  endfunction

  function automatic void ref_events(input logic [7:0] x);
    int e;
    e = int'(x[6:3]);
    if (e > 9) m_sat = (m_sat < 65535) ? m_sat + 1 : 65535;
    else if (e < 6 && x[6:0] != 7'd0) m_uf = (m_uf < 65535) ? m_uf + 1 : 65535;
  endfunction

  task automatic model_accept(input logic [15:0] d, input bit last, input bit cfg);
    logic [15:0] conv;
    pair_t p;
    if (m_sof) m_mode = cfg;
    if (m_mode) begin
      conv = {8'h00, ref_cvt(d[15:8]), ref_cvt(d[7:0])};
      ref_events(d[15:8]);
      ref_events(d[7:0]);
    end else begin
      conv = d;
    end
    pend.push_back(conv);
    if (pend.size() == 2 || last) begin
      p.a    = pend[0];
      p.b    = (pend.size() == 2) ? pend[1] : 16'h0000;
      p.fp4  = m_mode;
      p.last = last;
      sb.push_back(p);
      pend.delete();
    end
    m_sof = last;
  endtask

  task automatic model_reset();
    pend.delete();
    sb.delete();
    m_sof  = 1'b1;
    m_mode = 1'b0;
    m_sat  = 0;
    m_uf   = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] d, input bit last, input bit cfg);
    bit acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.cfg_fp4  = cfg;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      if (bus.in_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout data=%h", d);
    end else begin
      model_accept(d, last, cfg);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_sat"},   32'(sat_cnt),   CNT_ON ? 32'(m_sat) : 32'd0);
    chk({tag, "_uflow"}, 32'(uflow_cnt), CNT_ON ? 32'(m_uf)  : 32'd0);
  endtask

  // Scoreboard monitor: compares every pair the butterfly consumes.
  initial begin
    pair_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pair_unexpected a=%h b=%h", bus.out_a, bus.out_b);
        end else begin
          e = sb.pop_front();
          if (bus.out_a !== e.a || bus.out_b !== e.b || bus.out_fp4 !== e.fp4 || bus.out_last !== e.last) begin
            errors++;
            $display("FAIL pair got a=%h b=%h fp4=%b last=%b expected a=%h b=%h fp4=%b last=%b",
                     bus.out_a, bus.out_b, bus.out_fp4, bus.out_last, e.a, e.b, e.fp4, e.last);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.in_last   = 1'b0;
    bus.cfg_fp4   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_ab", {bus.out_a, bus.out_b}, 32'd0);
    chk("rst_tags", {30'd0, bus.out_fp4, bus.out_last}, 32'd0);
    chk("rst_cnt", {sat_cnt, uflow_cnt}, 32'd0);
    @(posedge clk);
    #1;

    // FP8 pass-through pair.
    send(16'h3C40, 1'b0, 1'b0);
    send(16'h48C8, 1'b1, 1'b0);
    drain();
    chk_counters("fp8");

    // FP4 conversion with one saturation and one underflow.
    do_reset();
    send(16'h3C48, 1'b0, 1'b1);
    send(16'h50A8, 1'b1, 1'b1);
    drain();
    chk("fp4_sat_abs", 32'(sat_cnt), CNT_ON ? 32'd1 : 32'd0);
    chk("fp4_uflow_abs", 32'(uflow_cnt), CNT_ON ? 32'd1 : 32'd0);

    // Odd frame and mid-frame cfg change.
    send(16'h4848, 1'b1, 1'b1);
    send(16'h3C48, 1'b0, 1'b0);
    send(16'h50A8, 1'b1, 1'b1);
    drain();
    chk_counters("odd_cfg");

    // Backpressure: FIFO fills after the 4th accept.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'(16'h3A00 + 16'(i * 16'h0111)), 1'b0, 1'b1);
    @(negedge clk);
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    fork
      begin
        send(16'h4C4C, 1'b0, 1'b0);
        send(16'h5252, 1'b1, 1'b0);
      end
      begin
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_resume", 32'(bus.in_ready), 32'd1);
      end
    join
    drain();
    chk_counters("bp");

    // Reset with A held: only the following pair appears.
    send(16'h5050, 1'b0, 1'b1);
    do_reset();
    @(negedge clk);
    chk("mid_rst_cnt", {sat_cnt, uflow_cnt}, 32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    send(16'h3C48, 1'b0, 1'b0);
    send(16'h4040, 1'b1, 1'b0);
    drain();
    chk_counters("mid_rst");

    // Randomized stream with random backpressure and cfg noise.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(16'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    send(16'h4444, 1'b1, 1'b0);
    drain();
    chk_counters("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
